// File: rtl/svpwm_scheduler.sv
// svpwm_scheduler: centre-aligned carrier, valley-synchronous duty double-buffer, gates.
// Optional dead-time insertion is compiled in when SVPWM_DEADTIME_EN is defined.
module svpwm_scheduler #(
    parameter int N        = 8,
    parameter int DEADTIME = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] period,
    output logic         sample,
    input  logic [N-1:0] duty_a,
    input  logic [N-1:0] duty_b,
    input  logic [N-1:0] duty_c,
    input  logic         duty_valid,
    output logic         duty_ready,
    output logic         miss,
    output logic         ga_h,
    output logic         gb_h,
    output logic         gc_h,
    output logic         ga_l,
    output logic         gb_l,
    output logic         gc_l
);
    typedef enum logic [1:0] {IDLE, WAIT_VALLEY, WAIT_DUTY, LOADED} state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [N-1:0]      cnt_q;
    logic [N-1:0]      period_q;
    logic              up_q;
    logic              pend_q;
    logic              sample_q;
    logic              miss_q;
    logic [2:0][N-1:0] act_q;
    logic [2:0][N-1:0] shd_q;
    logic [2:0]        gh_q;
    logic [2:0]        gl_q;

    logic              running;
    logic              valley;
    logic              peak;
    logic              xfer;
    logic              run;
    logic [2:0]        raw;
    logic [2:0]        quiet;
    logic [2:0][N-1:0] duty_in;

    if (DEADTIME < 1 || DEADTIME > 15) begin : g_dt_check
        $error("DEADTIME must be 1..15");
    end

    assign duty_in    = {duty_c, duty_b, duty_a};
    assign running    = state_q != IDLE;
    // Leaving IDLE parks the counter at 0/down so the first cycle is a valley.
    assign valley     = en && running && cnt_q == '0 && !up_q;
    assign peak       = running && up_q && cnt_q == period_q;
    assign duty_ready = state_q == WAIT_DUTY;
    assign xfer       = duty_valid && duty_ready;
    assign run        = en && running && period_q != '0;

    always_comb begin
        raw = '0;
        for (int i = 0; i < 3; i++) begin
            raw[i] = run && (cnt_q < act_q[i]);
        end
    end

`ifdef SVPWM_DEADTIME_EN
    logic [2:0]      prev_q;
    logic [2:0][3:0] dead_q;
    logic [2:0][3:0] dead_d;

    always_comb begin
        dead_d = dead_q;
        quiet  = '0;
        for (int i = 0; i < 3; i++) begin
            if (raw[i] != prev_q[i]) begin
                dead_d[i] = 4'(DEADTIME);
            end else if (dead_q[i] != 4'd0) begin
                dead_d[i] = dead_q[i] - 4'd1;
            end
            quiet[i] = dead_d[i] == 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            dead_q <= '0;
        end else begin
            prev_q <= raw;
            dead_q <= dead_d;
        end
    end
`else
    assign quiet = '1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            up_q     <= 1'b1;
            pend_q   <= 1'b0;
            sample_q <= 1'b0;
            miss_q   <= 1'b0;
            act_q    <= '0;
            shd_q    <= '0;
            gh_q     <= '0;
            gl_q     <= '0;
        end else begin
            sample_q <= 1'b0;
            miss_q   <= 1'b0;
            if (!en) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                up_q    <= 1'b1;
            end else if (state_q == IDLE) begin
                state_q <= WAIT_VALLEY;
                cnt_q   <= '0;
                up_q    <= 1'b0;
            end else begin
                if (valley) begin
                    period_q <= period;
                    sample_q <= 1'b1;
                    if (pend_q) act_q <= shd_q;
                    cnt_q    <= (period == '0) ? '0 : ONE;
                    up_q     <= period != '0;
                end else if (up_q) begin
                    if (cnt_q == period_q) begin
                        cnt_q <= cnt_q - ONE;
                        up_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end else begin
                    cnt_q <= cnt_q - ONE;
                end
                unique case (state_q)
                    WAIT_VALLEY, LOADED: begin
                        if (valley) state_q <= WAIT_DUTY;
                    end
                    WAIT_DUTY: begin
                        if (xfer) begin
                            state_q <= LOADED;
                        end else if (peak) begin
                            state_q <= WAIT_VALLEY;
                            miss_q  <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
            // A transfer coinciding with a valley wins the pend flag.
            if (xfer) begin
                shd_q  <= duty_in;
                pend_q <= 1'b1;
            end else if (valley) begin
                pend_q <= 1'b0;
            end
            gh_q <= raw & quiet;
            gl_q <= {3{run}} & ~raw & quiet;
        end
    end

    assign sample = sample_q;
    assign miss   = miss_q;
    assign ga_h   = gh_q[0];
    assign gb_h   = gh_q[1];
    assign gc_h   = gh_q[2];
    assign ga_l   = gl_q[0];
    assign gb_l   = gl_q[1];
    assign gc_l   = gl_q[2];
endmodule

// File: tb/tb_svpwm_scheduler.sv
// tb_svpwm_scheduler: random and directed stimulus against a carrier-phase reference model.
// Follows SVPWM_DEADTIME_EN so the same bench covers both builds.
module tb_svpwm_scheduler;
    localparam int N  = 8;
    localparam int DT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [N-1:0] period = '0;
    logic [N-1:0] duty_a = '0, duty_b = '0, duty_c = '0;
    logic         duty_valid = 1'b0;
    logic         sample, duty_ready, miss;
    logic         ga_h, gb_h, gc_h, ga_l, gb_l, gc_l;

    int total = 0;
    int bad = 0;

    svpwm_scheduler #(.N(N), .DEADTIME(DT)) dut (
        .clk(clk), .rst(rst), .en(en), .period(period), .sample(sample),
        .duty_a(duty_a), .duty_b(duty_b), .duty_c(duty_c),
        .duty_valid(duty_valid), .duty_ready(duty_ready), .miss(miss),
        .ga_h(ga_h), .gb_h(gb_h), .gc_h(gc_h),
        .ga_l(ga_l), .gb_l(gb_l), .gc_l(gc_l)
    );

    always #5 clk = ~clk;

    // Model: carrier as phase k in [0, 2P); cnt is the triangle of k.
    bit  m_idle;
    int  m_k, m_p;
    bit  m_want, m_pend, m_sample, m_miss;
    int  m_act[3], m_shd[3];
    bit  m_gh[3], m_gl[3];
    bit  hist[3][16];

    function automatic void model_reset();
        m_idle = 1; m_k = 0; m_p = 0; m_want = 0; m_pend = 0;
        m_sample = 0; m_miss = 0;
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 0; m_shd[i] = 0; m_gh[i] = 0; m_gl[i] = 0;
            for (int j = 0; j < 16; j++) hist[i][j] = 0;
        end
    endfunction

    function automatic void model_step();
        int  d[3];
        int  cnt;
        bit  valley, peak, xfer, run, steady;
        bit  raw[3];
        d[0] = int'(duty_a); d[1] = int'(duty_b); d[2] = int'(duty_c);
        cnt  = (m_k <= m_p) ? m_k : 2 * m_p - m_k;
        xfer = m_want && duty_valid;
        run  = en && !m_idle && m_p != 0;
        for (int i = 0; i < 3; i++) begin
            raw[i] = run && (cnt < m_act[i]);
            for (int j = 15; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = raw[i];
            steady = 1;
`ifdef SVPWM_DEADTIME_EN
            for (int j = 1; j <= DT; j++) if (hist[i][j] != raw[i]) steady = 0;
`endif
            m_gh[i] = run && steady && raw[i];
            m_gl[i] = run && steady && !raw[i];
        end
        valley = en && !m_idle && m_k == 0;
        peak   = !m_idle && m_p != 0 && m_k == m_p;
        m_sample = 0;
        m_miss   = 0;
        if (!en) begin
            m_idle = 1; m_k = 0; m_want = 0;
        end else if (m_idle) begin
            m_idle = 0; m_k = 0; m_want = 0;
        end else begin
            if (valley) begin
                m_sample = 1;
                m_p = int'(period);
                if (m_pend) begin
                    for (int i = 0; i < 3; i++) m_act[i] = m_shd[i];
                    m_pend = 0;
                end
                m_k = (m_p == 0) ? 0 : 1;
            end else begin
                m_k = (m_k + 1) % (2 * m_p);
            end
            if (m_want && !xfer && peak) m_miss = 1;
            if (xfer) m_want = 0;
            else if (valley) m_want = 1;
            else if (m_miss) m_want = 0;
        end
        if (xfer) begin
            for (int i = 0; i < 3; i++) m_shd[i] = d[i];
            m_pend = 1;
        end
    endfunction

    function automatic logic [8:0] obs();
        return {sample, miss, duty_ready, ga_h, gb_h, gc_h, ga_l, gb_l, gc_l};
    endfunction

    function automatic logic [8:0] expv();
        return {m_sample, m_miss, m_want, m_gh[0], m_gh[1], m_gh[2],
                m_gl[0], m_gl[1], m_gl[2]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs() !== 9'b0) begin
            bad++;
            $display("FAIL reset_hold got=%b exp=%b", obs(), 9'b0);
        end
        rst = 1'b0;
        model_reset();
        cyc();
        total++;
        if (obs() !== expv()) begin
            bad++;
            $display("FAIL reset_idle got=%b exp=%b", obs(), expv());
        end
    endtask

    task automatic test_steady();
        int last = -1;
        int gap = -1;
        period = 8'd10; duty_a = 8'd4; duty_b = 8'd4; duty_c = 8'd4;
        duty_valid = 1'b1; en = 1'b1;
        for (int c = 0; c < 90; c++) begin
            cyc();
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL steady c=%0d got=%b exp=%b", c, obs(), expv());
            end
            if (sample) begin
                if (last >= 0) gap = c - last;
                last = c;
            end
        end
        total++;
        if (gap !== 20) begin
            bad++;
            $display("FAIL sample_gap got=%0d exp=%0d", gap, 20);
        end
    endtask

    task automatic test_miss();
        int seen = 0;
        int want = 0;
        duty_valid = 1'b0;
        duty_a = 8'd7;
        for (int c = 0; c < 45; c++) begin
            cyc();
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL miss c=%0d got=%b exp=%b", c, obs(), expv());
            end
            seen += int'(miss);
            want += int'(m_miss);
        end
        total++;
        if (seen !== want || want == 0) begin
            bad++;
            $display("FAIL miss_count got=%0d exp=%0d", seen, want);
        end
    endtask

    task automatic test_extremes();
        period = 8'd10; duty_a = 8'd4; duty_b = 8'd0; duty_c = 8'd15;
        duty_valid = 1'b1;
        for (int c = 0; c < 70; c++) begin
            cyc();
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL extremes c=%0d got=%b exp=%b", c, obs(), expv());
            end
            if (c >= 50) begin
                total++;
                if ({gb_h, gb_l, gc_h, gc_l} !== 4'b0110) begin
                    bad++;
                    $display("FAIL extremes_bc c=%0d got=%b exp=%b",
                             c, {gb_h, gb_l, gc_h, gc_l}, 4'b0110);
                end
            end
        end
    endtask

    task automatic test_en_drop();
        bit found = 0;
        duty_b = 8'd5; duty_c = 8'd3;
        for (int c = 0; c < 60 && !found; c++) begin
            cyc();
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL en_wait c=%0d got=%b exp=%b", c, obs(), expv());
            end
            if (!m_idle && m_k >= 2 && m_k < m_p) found = 1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL en_upcount got=%0d exp=%0d", 0, 1);
        end
        en = 1'b0;
        cyc();
        total++;
        if (obs() !== 9'b0) begin
            bad++;
            $display("FAIL en_off got=%b exp=%b", obs(), 9'b0);
        end
        repeat (2) cyc();
        en = 1'b1;
        for (int c = 0; c < 30; c++) begin
            cyc();
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL en_restart c=%0d got=%b exp=%b", c, obs(), expv());
            end
            if (c == 1) begin
                total++;
                if (sample !== 1'b1) begin
                    bad++;
                    $display("FAIL en_first_sample got=%b exp=%b", sample, 1'b1);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        bit loaded = 0;
        duty_valid = 1'b1;
        for (int c = 0; c < 60 && !loaded; c++) begin
            duty_a = 8'($urandom_range(1, 9));
            cyc();
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL rst_wait c=%0d got=%b exp=%b", c, obs(), expv());
            end
            if (m_pend && !m_want && !m_idle) loaded = 1;
        end
        total++;
        if (!loaded) begin
            bad++;
            $display("FAIL rst_loaded got=%0d exp=%0d", 0, 1);
        end
        duty_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (obs() !== 9'b0) begin
            bad++;
            $display("FAIL rst_async got=%b exp=%b", obs(), 9'b0);
        end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            cyc();
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL rst_restart c=%0d got=%b exp=%b", c, obs(), expv());
            end
        end
        total++;
        if (ga_h !== 1'b0 || ga_l !== 1'b1) begin
            bad++;
            $display("FAIL rst_zero_duty got=%b exp=%b", {ga_h, ga_l}, 2'b01);
        end
    endtask

    task automatic test_random();
        int pers[6] = '{0, 1, 2, 3, 5, 10};
        for (int c = 0; c < 700; c++) begin
            if (c % 97 == 0) period = 8'(pers[$urandom_range(0, 5)]);
            if (c % 211 == 50) period = 8'($urandom_range(4, 40));
            en = ($urandom_range(0, 39) != 0);
            duty_valid = $urandom_range(0, 2) == 0;
            duty_a = 8'($urandom_range(0, 45));
            duty_b = 8'($urandom_range(0, 45));
            duty_c = 8'($urandom_range(0, 45));
            cyc();
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL random c=%0d got=%b exp=%b", c, obs(), expv());
            end
            total++;
            if ((ga_h & ga_l) | (gb_h & gb_l) | (gc_h & gc_l)) begin
                bad++;
                $display("FAIL overlap c=%0d got=%b exp=%b", c, 1'b1, 1'b0);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_steady();
        test_miss();
        test_extremes();
        test_en_drop();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end
endmodule
